// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM controller.
//   state_t    - controller FSM states (S_INIT .. S_DONE)
//   DEF_ADDR_W - default SRAM address width (2K locations)
//   DEF_DATA_W - default SRAM data width
//   SRAM_DEPTH - number of SRAM locations
//   max3()     - helper used to size the shared phase counter
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;
  localparam int SRAM_DEPTH = 2048;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: host-side request/response bundle of the SRAM controller.
//   req_valid/req_ready - single-beat request handshake
//   req_write           - 1 = write, 0 = read
//   req_addr/req_wdata  - request address and write data
//   rsp_valid           - one-cycle completion pulse
//   rsp_rdata           - read data, valid with rsp_valid on reads
// Modports: master = host side, slave = controller side.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter timing one FSM phase.
//   clk        - system clock
//   reset      - synchronous, active-high
//   i_load     - load i_load_val (phase length minus one)
//   i_load_val - reload value
//   o_done     - high during the last cycle of the phase (count == 0)
module sram_phase_timer
  import sram_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous master for a 2K x 8 asynchronous SRAM.
// Sequences each host request as SETUP -> STROBE -> HOLD -> DONE with
// registered, glitch-free SRAM strobes.
//   clk, reset             - clock, synchronous active-high reset
//   host (sram_ctrl_if)    - request/response handshake (slave side)
//   init_done              - controller ready for host traffic
//   sram_addr, sram_wdata  - SRAM address / write data
//   sram_rdata             - SRAM read data
//   sram_cs_n, sram_oe_n   - chip select / output enable, active low
//   sram_rnw               - read-not-write; write commits on its rising edge
// Optional macro SRAM_CTRL_CLEAR_EN: after reset, INIT zero-fills the whole
// SRAM before init_done rises.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset,
  sram_ctrl_if.slave        host,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_rnw
);
  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t            r_state, w_state_next;
  logic              r_write;
  logic              r_req_ready, r_rsp_valid, r_init_done;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cs_n, r_oe_n, r_rnw;
  logic              w_accept, w_phase_done, w_load;
  logic [CNT_W-1:0]  w_load_val;
`ifdef SRAM_CTRL_CLEAR_EN
  logic              r_sweep_active;
  logic [ADDR_W-1:0] r_sweep_addr;
  logic              w_sweep_last;
  assign w_sweep_last = (r_sweep_addr == ADDR_W'(SRAM_DEPTH - 1));
`endif

  // r_req_ready is only ever high in IDLE, so it doubles as the state test.
  assign w_accept = r_req_ready && host.req_valid;

  sram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_phase_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
`ifdef SRAM_CTRL_CLEAR_EN
      S_INIT:   w_state_next = r_sweep_active ? S_SETUP : S_IDLE;
`else
      S_INIT:   w_state_next = S_IDLE;
`endif
      S_IDLE:   if (w_accept) w_state_next = S_SETUP;
      S_SETUP:  if (w_phase_done) w_state_next = S_STROBE;
      S_STROBE: if (w_phase_done) w_state_next = S_HOLD;
      S_HOLD: begin
        if (w_phase_done) begin
`ifdef SRAM_CTRL_CLEAR_EN
          // Sweep writes chain HOLD -> SETUP directly: 4 cycles per address.
          if (r_sweep_active) w_state_next = w_sweep_last ? S_IDLE : S_SETUP;
          else                w_state_next = S_DONE;
`else
          w_state_next = S_DONE;
`endif
        end
      end
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_INIT;
    endcase
    // Every state change reloads the timer with the new phase length.
    if (w_state_next != r_state) begin
      w_load = 1'b1;
      case (w_state_next)
        S_SETUP:  w_load_val = SETUP_LD;
        S_STROBE: w_load_val = PULSE_LD;
        S_HOLD:   w_load_val = HOLD_LD;
        default:  w_load_val = '0;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state
  // and never glitch toward the asynchronous SRAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_write     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_init_done <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_rnw       <= 1'b1;
`ifdef SRAM_CTRL_CLEAR_EN
      r_sweep_active <= 1'b1;
      r_sweep_addr   <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == S_IDLE);
      r_rsp_valid <= (w_state_next == S_DONE);
      r_cs_n      <= !((w_state_next == S_SETUP) || (w_state_next == S_STROBE) ||
                       (w_state_next == S_HOLD));
      // STROBE is only entered from SETUP, so r_write is already settled.
      r_oe_n      <= !((w_state_next == S_STROBE) && !r_write);
      r_rnw       <= !((w_state_next == S_STROBE) && r_write);
      if (w_state_next == S_IDLE) r_init_done <= 1'b1;
      if (w_accept) begin
        r_write <= host.req_write;
        r_addr  <= host.req_addr;
        r_wdata <= host.req_wdata;
      end
      // Capture on the last STROBE edge while oe_n is still low.
      if ((r_state == S_STROBE) && w_phase_done && !r_write) r_rsp_rdata <= sram_rdata;
`ifdef SRAM_CTRL_CLEAR_EN
      if ((r_state == S_INIT) && r_sweep_active) begin
        r_write <= 1'b1;
        r_addr  <= r_sweep_addr;
        r_wdata <= '0;
      end
      if ((r_state == S_HOLD) && w_phase_done && r_sweep_active) begin
        r_sweep_addr <= r_sweep_addr + ADDR_W'(1);  // wraps to 0 after the last
        r_addr       <= r_sweep_addr + ADDR_W'(1);
        if (w_sweep_last) r_sweep_active <= 1'b0;
      end
`endif
    end
  end

  assign host.req_ready = r_req_ready;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_rdata = r_rsp_rdata;
  assign init_done      = r_init_done;
  assign sram_addr      = r_addr;
  assign sram_wdata     = r_wdata;
  assign sram_cs_n      = r_cs_n;
  assign sram_oe_n      = r_oe_n;
  assign sram_rnw       = r_rnw;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl.
// Two instances: u_dut0 with default timing, u_dut1 with 2/3/2 timing.
// Each has a behavioural async SRAM (write on rnw rising edge while selected,
// combinational read while cs_n and oe_n are low). Honours SRAM_CTRL_CLEAR_EN.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

`ifdef SRAM_CTRL_CLEAR_EN
  localparam int EXP_INIT0 = 2048 * 4 + 1;
  localparam int EXP_INIT1 = 2048 * 7 + 1;
`else
  localparam int EXP_INIT0 = 1;
  localparam int EXP_INIT1 = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sram_ctrl_if #(.ADDR_W(11), .DATA_W(8)) h0 ();
  sram_ctrl_if #(.ADDR_W(11), .DATA_W(8)) h1 ();

  logic [10:0] s0_addr, s1_addr;
  logic [7:0]  s0_wdata, s1_wdata, s0_rdata, s1_rdata;
  logic        s0_cs_n, s0_oe_n, s0_rnw, s1_cs_n, s1_oe_n, s1_rnw;
  logic        init0, init1;

  sram_ctrl #(.ADDR_W(11), .DATA_W(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut0 (
    .clk(clk), .reset(reset), .host(h0), .init_done(init0),
    .sram_addr(s0_addr), .sram_wdata(s0_wdata), .sram_rdata(s0_rdata),
    .sram_cs_n(s0_cs_n), .sram_oe_n(s0_oe_n), .sram_rnw(s0_rnw)
  );

  sram_ctrl #(.ADDR_W(11), .DATA_W(8), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut1 (
    .clk(clk), .reset(reset), .host(h1), .init_done(init1),
    .sram_addr(s1_addr), .sram_wdata(s1_wdata), .sram_rdata(s1_rdata),
    .sram_cs_n(s1_cs_n), .sram_oe_n(s1_oe_n), .sram_rnw(s1_rnw)
  );

  // SRAM models, preloaded with 0xFF.
  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) mem0[i] = 8'hFF;
    forever begin
      @(posedge s0_rnw);
      if (s0_cs_n === 1'b0) mem0[s0_addr] = s0_wdata;
    end
  end
  initial begin
    for (int i = 0; i < 2048; i++) mem1[i] = 8'hFF;
    forever begin
      @(posedge s1_rnw);
      if (s1_cs_n === 1'b0) mem1[s1_addr] = s1_wdata;
    end
  end
  assign s0_rdata = (!s0_cs_n && !s0_oe_n) ? mem0[s0_addr] : 8'hEE;
  assign s1_rdata = (!s1_cs_n && !s1_oe_n) ? mem1[s1_addr] : 8'hEE;

  // Shared stimulus steered to one DUT by sel; observation muxed back.
  logic        sel = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_write = 1'b0;
  logic [10:0] t_addr = '0;
  logic [7:0]  t_wdata = '0;

  assign h0.req_valid = t_valid & ~sel;
  assign h0.req_write = t_write;
  assign h0.req_addr  = t_addr;
  assign h0.req_wdata = t_wdata;
  assign h1.req_valid = t_valid & sel;
  assign h1.req_write = t_write;
  assign h1.req_addr  = t_addr;
  assign h1.req_wdata = t_wdata;

  logic        o_ready, o_rsp_valid, o_init, o_cs_n, o_oe_n, o_rnw;
  logic [7:0]  o_rdata, o_wdata;
  logic [10:0] o_addr;
  assign o_ready     = sel ? h1.req_ready : h0.req_ready;
  assign o_rsp_valid = sel ? h1.rsp_valid : h0.rsp_valid;
  assign o_rdata     = sel ? h1.rsp_rdata : h0.rsp_rdata;
  assign o_init      = sel ? init1 : init0;
  assign o_cs_n      = sel ? s1_cs_n : s0_cs_n;
  assign o_oe_n      = sel ? s1_oe_n : s0_oe_n;
  assign o_rnw       = sel ? s1_rnw : s0_rnw;
  assign o_addr      = sel ? s1_addr : s0_addr;
  assign o_wdata     = sel ? s1_wdata : s0_wdata;

  // Waits (from a negedge just after reset release) for both init_done flags.
  task automatic wait_init();
    int n, n0, n1;
    n = 0; n0 = -1; n1 = -1;
    while ((n0 < 0 || n1 < 0) && n < 20000) begin
      @(negedge clk);
      n++;
      if (init0 && n0 < 0) n0 = n;
      if (init1 && n1 < 0) n1 = n;
    end
    $display("init: dut0 after %0d cycles, dut1 after %0d cycles", n0, n1);
    checks++;
    if (n0 !== EXP_INIT0) begin
      errors++; $display("FAIL init0_latency: got %0d expected %0d", n0, EXP_INIT0);
    end
    checks++;
    if (n1 !== EXP_INIT1) begin
      errors++; $display("FAIL init1_latency: got %0d expected %0d", n1, EXP_INIT1);
    end
  endtask

  // One host transaction on the selected DUT, observed every cycle at negedge.
  // lat counts cycles from the accept edge; the DONE cycle has lat = S+P+H+1.
  task automatic do_op(input bit wr, input logic [10:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output int oe_cnt,
                       output int rnw_cnt, output bit unstable, output bit overlap);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL op_ready_timeout: req_ready=%b expected 1", o_ready);
    end
    t_valid = 1'b1; t_write = wr; t_addr = a; t_wdata = d;
    lat = 0; oe_cnt = 0; rnw_cnt = 0; unstable = 0; overlap = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) t_valid = 1'b0;
      if (!o_oe_n) oe_cnt++;
      if (!o_rnw) rnw_cnt++;
      if (!o_oe_n && !o_rnw) overlap = 1;
      if (!o_cs_n && (o_addr !== a || (wr && o_wdata !== d))) unstable = 1;
    end while (!o_rsp_valid && lat < 40);
    rd = o_rdata;
    $display("op dut%0d %s addr=%h wdata=%h rdata=%h lat=%0d oe=%0d rnw=%0d",
             sel, wr ? "WR" : "RD", a, d, rd, lat, oe_cnt, rnw_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1; t_valid = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_ready, o_rsp_valid, o_init} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_rsp_init: got %b expected 000", {o_ready, o_rsp_valid, o_init});
    end
    checks++;
    if (o_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00", o_rdata);
    end
    checks++;
    if ({o_cs_n, o_oe_n, o_rnw} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b expected 111", {o_cs_n, o_oe_n, o_rnw});
    end
    checks++;
    if ({o_addr, o_wdata} !== 19'd0) begin
      errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 000/00", o_addr, o_wdata);
    end
    reset = 1'b0;
    wait_init();
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_init: got %b expected 1", o_ready);
    end
  endtask

`ifdef SRAM_CTRL_CLEAR_EN
  task automatic test_clear();
    int lat, oe, rw; logic [7:0] rd; bit us, ov;
    logic [10:0] addrs [3];
    addrs[0] = 11'h000; addrs[1] = 11'h400; addrs[2] = 11'h7FF;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, addrs[i], 8'h00, lat, rd, oe, rw, us, ov);
      checks++;
      if (rd !== 8'h00) begin
        errors++; $display("FAIL clear_read_%h: got %h expected 00", addrs[i], rd);
      end
    end
  endtask
`endif

  task automatic test_write_read();
    int lat, oe, rw; logic [7:0] rd; bit us, ov;
    do_op(1'b1, 11'h123, 8'hA5, lat, rd, oe, rw, us, ov);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wr_latency: got %0d expected 5", lat); end
    checks++;
    if (rw !== 2 || oe !== 0) begin
      errors++; $display("FAIL wr_strobe_len: rnw=%0d oe=%0d expected 2/0", rw, oe);
    end
    checks++;
    if (us !== 1'b0) begin errors++; $display("FAIL wr_addr_stable: unstable=%b expected 0", us); end
    checks++;
    if (mem0[11'h123] !== 8'hA5) begin
      errors++; $display("FAIL wr_mem: got %h expected a5", mem0[11'h123]);
    end
    do_op(1'b0, 11'h123, 8'h00, lat, rd, oe, rw, us, ov);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL rd_latency: got %0d expected 5", lat); end
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h expected a5", rd); end
    checks++;
    if (oe !== 2 || rw !== 0 || us !== 1'b0) begin
      errors++; $display("FAIL rd_strobes: oe=%0d rnw=%0d unstable=%b expected 2/0/0", oe, rw, us);
    end
  endtask

  task automatic test_back_to_back();
    int n, lat, oe, rw; logic [7:0] rd; bit us, ov;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    t_valid = 1'b1; t_write = 1'b1; t_addr = 11'h000; t_wdata = 8'h11;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_rsp_valid && n < 20);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", n); end
    // Now in DONE with req_valid still high: switch to the second request.
    t_addr = 11'h7FF; t_wdata = 8'h22;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", o_ready); end
    @(negedge clk);
    checks++;
    if (o_cs_n !== 1'b0 || o_addr !== 11'h7FF) begin
      errors++; $display("FAIL b2b_second_accept: cs_n=%b addr=%h expected 0/7ff", o_cs_n, o_addr);
    end
    t_valid = 1'b0;
    n = 1;
    while (!o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 5", n); end
    $display("b2b: wrote 000=11 and 7ff=22 back to back");
    do_op(1'b0, 11'h000, 8'h00, lat, rd, oe, rw, us, ov);
    checks++;
    if (rd !== 8'h11) begin errors++; $display("FAIL b2b_read_000: got %h expected 11", rd); end
    do_op(1'b0, 11'h7FF, 8'h00, lat, rd, oe, rw, us, ov);
    checks++;
    if (rd !== 8'h22) begin errors++; $display("FAIL b2b_read_7ff: got %h expected 22", rd); end
  endtask

  task automatic test_ignore();
    int n, extra; logic [7:0] prior;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    prior = mem0[11'h200];
    t_valid = 1'b1; t_write = 1'b0; t_addr = 11'h123;
    @(negedge clk);                               // SETUP
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL ign_ready_setup: got %b expected 0", o_ready); end
    t_write = 1'b1; t_addr = 11'h200; t_wdata = 8'h77;
    @(negedge clk);                               // STROBE 1
    t_valid = 1'b0;
    @(negedge clk);                               // STROBE 2
    @(negedge clk);                               // HOLD
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL ign_ready_hold: got %b expected 0", o_ready); end
    t_valid = 1'b1;
    @(negedge clk);                               // DONE
    t_valid = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rdata !== 8'hA5) begin
      errors++; $display("FAIL ign_response: rsp_valid=%b rdata=%h expected 1/a5", o_rsp_valid, o_rdata);
    end
    extra = 0;
    repeat (12) begin @(negedge clk); if (o_rsp_valid) extra++; end
    $display("ignore: read 123 with stray pulses, extra responses=%0d", extra);
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ign_extra_rsp: got %0d expected 0", extra); end
    checks++;
    if (mem0[11'h200] !== prior) begin
      errors++; $display("FAIL ign_mem_untouched: got %h expected %h", mem0[11'h200], prior);
    end
  endtask

  task automatic test_params();
    int lat, oe, rw; logic [7:0] rd; bit us, ov;
    sel = 1'b1;
    do_op(1'b1, 11'h0AA, 8'h5A, lat, rd, oe, rw, us, ov);
    checks++;
    if (lat !== 8 || rw !== 3) begin
      errors++; $display("FAIL p_wr_timing: lat=%0d rnw=%0d expected 8/3", lat, rw);
    end
    do_op(1'b0, 11'h0AA, 8'h00, lat, rd, oe, rw, us, ov);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL p_rd_latency: got %0d expected 8", lat); end
    checks++;
    if (oe !== 3 || ov !== 1'b0) begin
      errors++; $display("FAIL p_rd_strobes: oe=%0d overlap=%b expected 3/0", oe, ov);
    end
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL p_rd_data: got %h expected 5a", rd); end
    sel = 1'b0;
  endtask

  task automatic test_reset_midop();
    int n, lat, oe, rw; logic [7:0] rd; bit us, ov;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    t_valid = 1'b1; t_write = 1'b1; t_addr = 11'h055; t_wdata = 8'h3C;
    @(negedge clk);                               // SETUP
    t_valid = 1'b0;
    @(negedge clk);                               // STROBE 1
    @(negedge clk);                               // STROBE 2
    checks++;
    if (o_rnw !== 1'b0) begin errors++; $display("FAIL mid_in_strobe: rnw=%b expected 0", o_rnw); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_cs_n, o_oe_n, o_rnw, o_rsp_valid} !== 4'b1110) begin
      errors++; $display("FAIL mid_reset_outputs: cs/oe/rnw/rsp=%b expected 1110",
                         {o_cs_n, o_oe_n, o_rnw, o_rsp_valid});
    end
    @(negedge clk);
    reset = 1'b0;
    $display("midop: reset during write strobe of 055");
    wait_init();
    do_op(1'b0, 11'h055, 8'h00, lat, rd, oe, rw, us, ov);
    checks++;
    if (lat !== 5 || oe !== 2) begin
      errors++; $display("FAIL mid_read_after: lat=%0d oe=%0d expected 5/2", lat, oe);
    end
  endtask

  initial begin
    test_reset();
`ifdef SRAM_CTRL_CLEAR_EN
    test_clear();
`endif
    test_write_read();
    test_back_to_back();
    test_ignore();
    test_params();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
